// File: rtl/dragon_chaser.sv
// rtl/dragon_chaser.sv - dragon head position, length and behaviour state controller
module dragon_chaser #(
    parameter int                     COORD_W        = 4,
    parameter int                     MOVE_PERIOD    = 4,
    parameter int                     RETREAT_FRAMES = 60,
    parameter int                     SCATTER_FRAMES = 90,
    parameter int                     LEN_W          = 4,
    parameter int                     INIT_LEN       = 3,
    parameter int                     MAX_LEN        = 15,
    parameter logic [2*COORD_W-1:0]   START_LOC      = {4'd7, 4'd7},
    parameter logic [7:0]             LFSR_SEED      = 8'hA5
) (
    input  logic                   frame_clk,
    input  logic                   rst,
    input  logic [2*COORD_W-1:0]   player_location,
    input  logic [2*COORD_W-1:0]   sheep_location,
    input  logic                   dragon_hurt,
    input  logic                   dragon_win,
    output logic [2*COORD_W-1:0]   dragon_head_location,
    output logic [1:0]             dragon_head_direction,
    output logic [LEN_W-1:0]       dragon_body_length,
    output logic [1:0]             behaviour_state,
    output logic                   move_strobe
);

    localparam int CW    = COORD_W;
    localparam int LW    = 2 * COORD_W;
    localparam int CNT_W = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam int TMAX  = (RETREAT_FRAMES > SCATTER_FRAMES) ? RETREAT_FRAMES : SCATTER_FRAMES;
    localparam int TMR_W = $clog2(TMAX + 1);
    localparam logic [CW-1:0] CMAX = '1;

    typedef enum logic [1:0] {
        ST_CONTEST = 2'd0,
        ST_RETREAT = 2'd1,
        ST_SCATTER = 2'd2,
        ST_DEAD    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     head_q, head_d;
    logic [1:0]        dir_q, dir_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              strobe_q, strobe_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [LW-1:0]     target_q, target_d;

    logic [LW-1:0]     tgt, nxt_loc;
    logic [CW-1:0]     hx, hy, tx, ty, nx, ny;
    logic [CW:0]       adx, ady, dist_p, dist_s;
    logic [1:0]        nxt_dir;
    logic              step, reach, move_en;

    function automatic logic [CW:0] absdiff(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a > b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    endfunction

    always_ff @(posedge frame_clk) begin
        if (rst) begin
            state_q  <= ST_CONTEST;
            head_q   <= START_LOC;
            dir_q    <= 2'd0;
            len_q    <= LEN_W'(INIT_LEN);
            strobe_q <= 1'b0;
            cnt_q    <= '0;
            tmr_q    <= '0;
            lfsr_q   <= LFSR_SEED;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            dir_q    <= dir_d;
            len_q    <= len_d;
            strobe_q <= strobe_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
            lfsr_q   <= lfsr_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        step     = (cnt_q == CNT_W'(MOVE_PERIOD - 1));
        cnt_d    = step ? '0 : cnt_q + CNT_W'(1);

        // Contest chases whichever of player/sheep is nearer; ties favour the sheep
        dist_p   = absdiff(player_location[LW-1:CW], head_q[LW-1:CW])
                 + absdiff(player_location[CW-1:0], head_q[CW-1:0]);
        dist_s   = absdiff(sheep_location[LW-1:CW], head_q[LW-1:CW])
                 + absdiff(sheep_location[CW-1:0], head_q[CW-1:0]);
        if (state_q == ST_CONTEST)
            tgt = (dist_p < dist_s) ? player_location : sheep_location;
        else
            tgt = target_q;

        hx      = head_q[LW-1:CW];
        hy      = head_q[CW-1:0];
        tx      = tgt[LW-1:CW];
        ty      = tgt[CW-1:0];
        adx     = absdiff(tx, hx);
        ady     = absdiff(ty, hy);
        nx      = hx;
        ny      = hy;
        nxt_dir = dir_q;
        if (head_q != tgt) begin
            if (adx >= ady) begin
                if (tx > hx) begin
                    nx      = hx + CW'(1);
                    nxt_dir = 2'd1;
                end else begin
                    nx      = hx - CW'(1);
                    nxt_dir = 2'd3;
                end
            end else begin
                if (ty > hy) begin
                    ny      = hy + CW'(1);
                    nxt_dir = 2'd2;
                end else begin
                    ny      = hy - CW'(1);
                    nxt_dir = 2'd0;
                end
            end
        end
        nxt_loc = {nx, ny};
        reach   = step && (nxt_loc == tgt);

        state_d  = state_q;
        len_d    = len_q;
        target_d = target_q;
        case (state_q)
            ST_CONTEST, ST_SCATTER: begin
                if (dragon_hurt) begin
                    len_d    = len_q - LEN_W'(1);
                    state_d  = (len_q == LEN_W'(1)) ? ST_DEAD : ST_RETREAT;
                    target_d = {lfsr_q[0] ? CMAX : '0, lfsr_q[1] ? CMAX : '0};
                end else if (state_q == ST_CONTEST && dragon_win) begin
                    len_d    = (len_q >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_q + LEN_W'(1);
                    state_d  = ST_SCATTER;
                    target_d = lfsr_q[LW-1:0];
                end else if (state_q == ST_SCATTER &&
                             (reach || tmr_q == TMR_W'(SCATTER_FRAMES - 1))) begin
                    state_d  = ST_CONTEST;
                end
            end
            ST_RETREAT: begin
                if (reach || tmr_q == TMR_W'(RETREAT_FRAMES - 1))
                    state_d = ST_CONTEST;
            end
            default: ;
        endcase

        if (state_d != state_q)
            tmr_d = '0;
        else if (state_q == ST_RETREAT || state_q == ST_SCATTER)
            tmr_d = tmr_q + TMR_W'(1);
        else
            tmr_d = '0;

        // A dying dragon freezes on the event edge itself, even if it was a step edge
        move_en  = step && (state_q != ST_DEAD) && (state_d != ST_DEAD);
        head_d   = move_en ? nxt_loc : head_q;
        dir_d    = move_en ? nxt_dir : dir_q;
        strobe_d = move_en;
    end

    assign dragon_head_location  = head_q;
    assign dragon_head_direction = dir_q;
    assign dragon_body_length    = len_q;
    assign behaviour_state       = state_q;
    assign move_strobe           = strobe_q;

endmodule
